// File: rtl/gp_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module   : gp_cmd_writer
// Brief    : Packs streamed 32-bit GP command words into 256-bit DRAM bursts
//            (two 128-bit wdf beats) and writes them to a command list through
//            the af/wdf request FIFOs.
// Config   : define GPW_AUTO_TERMINATE_EN to append a 32'h0 GP stop word on
//            flush (counted in words_written, may spill into a new burst).
// Revision : 1.0 - initial release
// ============================================================================
module gp_cmd_writer #(
  parameter int BURST_WORDS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             cmd_valid,
  input  logic [31:0]      cmd_data,
  output logic             cmd_ready,
  input  logic             cmd_flush,
  input  logic             af_full,
  output logic             af_wr_en,
  output logic [2:0]       af_cmd_din,
  output logic [30:0]      af_addr_din,
  input  logic             wdf_full,
  output logic             wdf_wr_en,
  output logic [127:0]     wdf_din,
  output logic [15:0]      wdf_mask_din,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_written
);

  localparam logic [3:0] C_FULL_FILL = 4'(BURST_WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_WR0  = 3'd2,
    S_WR1  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       fill_q, fill_d;
  logic [7:0][31:0] slots_q, slots_d;
  logic [31:0]      addr_q, addr_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] words_q, words_d;
`ifdef GPW_AUTO_TERMINATE_EN
  // Stop word still owed after a flush that landed on a full burst.
  logic             term_q, term_d;
`endif

  logic             accept;
  logic [3:0]       fill_acc;
  logic [CNT_W-1:0] words_acc;
  logic [31:0]      mask_all;

  // Low address bits are dropped: bursts are always 32-byte aligned.
  logic unused_base;
  assign unused_base = ^base_addr[4:0];

  assign af_cmd_din    = 3'b000;
  assign words_written = words_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // State and datapath registers; reset drops everything, including a half-issued burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      slots_q <= '0;
      addr_q  <= '0;
      flush_q <= 1'b0;
      words_q <= '0;
`ifdef GPW_AUTO_TERMINATE_EN
      term_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      slots_q <= slots_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
      words_q <= words_d;
`ifdef GPW_AUTO_TERMINATE_EN
      term_q  <= term_d;
`endif
    end
  end

  // Byte mask per staged word: every slot at or beyond the fill count is not written.
  always_comb begin
    mask_all = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) >= fill_q) begin
        mask_all[4*k +: 4] = 4'hF;
      end
    end
  end

  // Next-state logic and FIFO push outputs.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    slots_d      = slots_q;
    addr_d       = addr_q;
    flush_d      = flush_q;
    words_d      = words_q;
`ifdef GPW_AUTO_TERMINATE_EN
    term_d       = term_q;
`endif
    cmd_ready    = 1'b0;
    af_wr_en     = 1'b0;
    af_addr_din  = '0;
    wdf_wr_en    = 1'b0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    busy         = 1'b0;
    done         = 1'b0;
    accept       = 1'b0;
    fill_acc     = fill_q;
    words_acc    = words_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          addr_d  = {base_addr[31:5], 5'b0};
          fill_d  = '0;
          slots_d = '0;
          flush_d = 1'b0;
          words_d = '0;
`ifdef GPW_AUTO_TERMINATE_EN
          term_d  = 1'b0;
`endif
        end
      end

      S_FILL: begin
        busy = 1'b1;
`ifdef GPW_AUTO_TERMINATE_EN
        cmd_ready = !term_q;
`else
        cmd_ready = 1'b1;
`endif
        accept = cmd_valid && cmd_ready;
        // The accepted word is stored before any flush in the same cycle.
        if (accept) begin
          slots_d[fill_q[2:0]] = cmd_data;
          fill_acc             = fill_q + 4'd1;
          words_acc            = sat_inc(words_q);
        end
        fill_d  = fill_acc;
        words_d = words_acc;
`ifdef GPW_AUTO_TERMINATE_EN
        if (term_q) begin
          // Spilled stop word goes to slot 0, which was cleared after the last burst.
          slots_d[0] = '0;
          fill_d     = 4'd1;
          flush_d    = 1'b1;
          term_d     = 1'b0;
          state_d    = S_WR0;
        end else if (cmd_flush) begin
          // The stop word is counted at flush time even if it spills.
          words_d = sat_inc(words_acc);
          if (fill_acc == C_FULL_FILL) begin
            term_d  = 1'b1;
            state_d = S_WR0;
          end else begin
            slots_d[fill_acc[2:0]] = '0;
            fill_d                 = fill_acc + 4'd1;
            flush_d                = 1'b1;
            state_d                = S_WR0;
          end
        end else if (fill_acc == C_FULL_FILL) begin
          state_d = S_WR0;
        end
`else
        if (cmd_flush) begin
          if (fill_acc == 4'd0) begin
            state_d = S_DONE;
          end else begin
            flush_d = 1'b1;
            state_d = S_WR0;
          end
        end else if (fill_acc == C_FULL_FILL) begin
          state_d = S_WR0;
        end
`endif
      end

      S_WR0: begin
        busy = 1'b1;
        // Address and first beat go together so the af entry never leads its data.
        if (!af_full && !wdf_full) begin
          af_wr_en     = 1'b1;
          af_addr_din  = {2'b00, addr_q[31:3]};
          wdf_wr_en    = 1'b1;
          wdf_din      = slots_q[3:0];
          wdf_mask_din = mask_all[15:0];
          state_d      = S_WR1;
        end
      end

      S_WR1: begin
        busy = 1'b1;
        if (!wdf_full) begin
          wdf_wr_en    = 1'b1;
          wdf_din      = slots_q[7:4];
          wdf_mask_din = mask_all[31:16];
          addr_d       = addr_q + 32'd32;
          fill_d       = '0;
          slots_d      = '0;
          if (flush_q) begin
            flush_d = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gp_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gp_cmd_writer
// Brief    : Self-checking bench for gp_cmd_writer. A queue-based model turns
//            accepted words into expected bursts; one negedge process compares
//            every push, handshake and status output against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gp_cmd_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic         cmd_valid = 1'b0;
  logic [31:0]  cmd_data = '0;
  logic         cmd_ready;
  logic         cmd_flush = 1'b0;
  logic         af_full = 1'b0;
  logic         af_wr_en;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic         wdf_full = 1'b0;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic         busy;
  logic         done;
  logic [15:0]  words_written;

  always #5 clk = ~clk;

  gp_cmd_writer #(.BURST_WORDS(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cmd_flush(cmd_flush), .af_full(af_full), .af_wr_en(af_wr_en),
    .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .wdf_full(wdf_full),
    .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din),
    .busy(busy), .done(done), .words_written(words_written)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [127:0] data;
    logic [15:0]  mask;
    logic         first;
    logic         last;
    logic [30:0]  addr;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] cur[$];
  bit          m_active = 0;
  bit          done_next = 0;
  logic [31:0] m_addr = '0;
  logic [15:0] m_words = '0;

  // Per-list captures of what the DUT pushed, for literal checks.
  int           list_af = 0;
  int           list_wdf = 0;
  logic [30:0]  cap_a [4];
  logic [127:0] cap_b0[4];
  logic [127:0] cap_b1[4];
  logic [15:0]  cap_k0[4];
  logic [15:0]  cap_k1[4];

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Turn the current group of words into two expected beats at the model address.
  function automatic void emit(input bit last);
    beat_t       b0, b1;
    logic [31:0] w;
    logic [3:0]  nib;
    b0.data = '0; b0.mask = '0; b0.first = 1'b1; b0.last = 1'b0;
    b0.addr = {2'b00, m_addr[31:3]};
    b1.data = '0; b1.mask = '0; b1.first = 1'b0; b1.last = last; b1.addr = '0;
    for (int k = 0; k < 8; k++) begin
      w   = (k < cur.size()) ? cur[k] : 32'h0;
      nib = (k < cur.size()) ? 4'h0 : 4'hF;
      if (k < 4) begin
        b0.data[32*k +: 32] = w;
        b0.mask[4*k +: 4]   = nib;
      end else begin
        b1.data[32*(k-4) +: 32] = w;
        b1.mask[4*(k-4) +: 4]   = nib;
      end
    end
    beats.push_back(b0);
    beats.push_back(b1);
    m_addr = m_addr + 32'd32;
    cur.delete();
  endfunction

  bit    exp_ready, exp_busy, done_now, idle_m;
  beat_t b;

  // Compare outputs against the model, then advance the model by this cycle's inputs.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_af_wr_en", af_wr_en, 0);
      chk("rst_wdf_wr_en", wdf_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_words", words_written, 0);
      chk("rst_wdf_din", wdf_din, 0);
      chk("rst_mask", wdf_mask_din, 0);
      chk("rst_af_addr", af_addr_din, 0);
      beats.delete(); cur.delete();
      m_active = 0; done_next = 0; m_words = '0;
    end else begin
      exp_ready = m_active && (beats.size() == 0);
      exp_busy  = m_active || (beats.size() != 0);
      done_now  = done_next;
      done_next = 0;
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("busy", busy, exp_busy);
      chk("done", done, done_now);
      chk("words_written", words_written, m_words);
      if (wdf_wr_en) begin
        if (beats.size() == 0) begin
          chk("unexpected_wdf_push", wdf_wr_en, 0);
        end else begin
          b = beats.pop_front();
          chk("wdf_din", wdf_din, b.data);
          chk("wdf_mask_din", wdf_mask_din, b.mask);
          chk("af_with_beat0", af_wr_en, b.first);
          chk("wdf_push_while_full", wdf_full, 0);
          if (b.first) begin
            chk("af_addr_din", af_addr_din, b.addr);
            chk("af_cmd_din", af_cmd_din, 0);
            chk("af_push_while_full", af_full, 0);
            if (list_af < 4) begin
              cap_a[list_af]  = af_addr_din;
              cap_b0[list_af] = wdf_din;
              cap_k0[list_af] = wdf_mask_din;
            end
            list_af++;
          end else if (list_af >= 1 && list_af <= 4) begin
            cap_b1[list_af-1] = wdf_din;
            cap_k1[list_af-1] = wdf_mask_din;
          end
          list_wdf++;
          if (b.last) done_next = 1;
        end
      end else if (af_wr_en) begin
        chk("af_push_without_beat", af_wr_en, 0);
      end

      idle_m = !exp_busy && !done_now;
      if (idle_m && start) begin
        m_active = 1;
        m_addr   = {base_addr[31:5], 5'b0};
        m_words  = '0;
        cur.delete();
        list_af  = 0;
        list_wdf = 0;
      end else if (exp_ready) begin
        if (cmd_valid) begin
          cur.push_back(cmd_data);
          m_words = sat16(m_words);
          if (cur.size() == 8) emit(1'b0);
        end
        if (cmd_flush) begin
          m_active = 0;
`ifdef GPW_AUTO_TERMINATE_EN
          cur.push_back(32'h0);
          m_words = sat16(m_words);
          emit(1'b1);
`else
          if (cur.size() != 0) begin
            emit(1'b1);
          end else if (cmd_valid) begin
            b = beats.pop_back();
            b.last = 1'b1;
            beats.push_back(b);
          end else begin
            done_next = 1;
          end
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_full(input int fprob);
    if (fprob >= 0) begin
      af_full  = ($urandom_range(0, 99) < fprob);
      wdf_full = ($urandom_range(0, 99) < fprob);
    end
  endtask

  task automatic begin_list(input logic [31:0] b);
    base_addr = b;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // fprob < 0 leaves af_full/wdf_full under the caller's control.
  task automatic send_words(input int n, input int vprob, input int fprob,
                            input bit seq, input logic [31:0] seq0, input bit stray_start);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 2000) begin
      cmd_valid = ($urandom_range(0, 99) < vprob);
      cmd_data  = seq ? seq0 + 32'(sent) : $urandom;
      start     = stray_start && ($urandom_range(0, 19) == 0);
      base_addr = $urandom;
      rand_full(fprob);
      @(negedge clk);
      if (cmd_valid && cmd_ready) sent++;
      cyc();
      guard++;
    end
    cmd_valid = 1'b0;
    start = 1'b0;
    chk("send_timeout", (guard < 2000), 1);
  endtask

  task automatic do_flush(input bit with_word, input int fprob);
    int guard = 0;
    bit taken = 0;
    bit got = 0;
    cmd_flush = 1'b1;
    cmd_valid = with_word;
    cmd_data  = $urandom;
    while (!taken && guard < 500) begin
      rand_full(fprob);
      @(negedge clk);
      taken = cmd_ready;
      cyc();
      guard++;
    end
    cmd_flush = 1'b0;
    cmd_valid = 1'b0;
    chk("flush_timeout", taken, 1);
    guard = 0;
    while (!got && guard < 500) begin
      @(negedge clk);
      got = done;
      cyc();
      rand_full(fprob);
      guard++;
    end
    af_full = 1'b0;
    wdf_full = 1'b0;
    chk("done_timeout", got, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    #2 rst = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_words", words_written, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    cyc();

    // 1: eight sequential words at 0x1040_0000.
    begin_list(32'h1040_0000);
    send_words(8, 100, 0, 1, 32'h0, 0);
    do_flush(0, 0);
    chk("t1_addr", cap_a[0], 31'h0208_0000);
    chk("t1_beat0", cap_b0[0], 128'h00000003_00000002_00000001_00000000);
    chk("t1_beat1", cap_b1[0], 128'h00000007_00000006_00000005_00000004);
    chk("t1_mask0", cap_k0[0], 16'h0000);
    chk("t1_mask1", cap_k1[0], 16'h0000);
`ifdef GPW_AUTO_TERMINATE_EN
    chk("t1_bursts", list_af, 2);
    chk("t1_words", words_written, 9);
    chk("t1_stop_mask", cap_k0[1], 16'hFFF0);
`else
    chk("t1_bursts", list_af, 1);
    chk("t1_words", words_written, 8);
`endif

    // 2: three words then flush.
    begin_list(32'h0000_101F);
    send_words(3, 100, 0, 1, 32'hA0, 0);
    do_flush(0, 0);
    chk("t2_bursts", list_af, 1);
    chk("t2_addr", cap_a[0], 31'h0000_0200);
    chk("t2_mask1", cap_k1[0], 16'hFFFF);
`ifdef GPW_AUTO_TERMINATE_EN
    chk("t2_mask0", cap_k0[0], 16'h0000);
    chk("t2_beat0", cap_b0[0], 128'h00000000_000000A2_000000A1_000000A0);
    chk("t2_words", words_written, 4);
`else
    chk("t2_mask0", cap_k0[0], 16'hF000);
    chk("t2_beat0", cap_b0[0], 128'h00000000_000000A2_000000A1_000000A0);
    chk("t2_words", words_written, 3);
`endif

    // 3: af_full held in WR0, then wdf_full in WR1.
    begin_list(32'h0000_4000);
    af_full = 1'b1;
    send_words(8, 100, -1, 1, 32'h100, 0);
    repeat (5) cyc();
    chk("t3_held_af", list_af, 0);
    af_full = 1'b0;
    got = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (af_wr_en) begin got = 1; break; end
      cyc();
    end
    cyc();
    chk("t3_af_release", got, 1);
    wdf_full = 1'b1;
    repeat (3) cyc();
    chk("t3_beat1_held", list_wdf, 1);
    wdf_full = 1'b0;
    cyc();
    chk("t3_beat1_data", cap_b1[0], 128'h00000107_00000106_00000105_00000104);
    do_flush(0, -1);

    // 4: sixteen words -> two consecutive bursts.
    begin_list(32'h2000_0000);
    send_words(16, 70, 20, 0, 32'h0, 0);
    do_flush(0, 20);
    chk("t4_addr0", cap_a[0], 31'h0400_0000);
    chk("t4_addr1", cap_a[1], 31'h0400_0004);

    // 5: empty flush.
    begin_list(32'h0000_8000);
    do_flush(0, 0);
`ifdef GPW_AUTO_TERMINATE_EN
    chk("t5_bursts", list_af, 1);
    chk("t5_mask0", cap_k0[0], 16'hFFF0);
    chk("t5_word0", cap_b0[0], 128'h0);
`else
    chk("t5_bursts", list_af, 0);
    chk("t5_words", words_written, 0);
`endif

    // 6: reset while stalled in WR1, then a fresh list.
    begin_list(32'h0000_C000);
    send_words(8, 100, -1, 0, 32'h0, 0);
    got = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (af_wr_en) begin got = 1; break; end
      cyc();
    end
    cyc();
    chk("t6_af_seen", got, 1);
    wdf_full = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("t6_busy_now", busy, 0);
    chk("t6_wdf_now", wdf_wr_en, 0);
    chk("t6_words_now", words_written, 0);
    cyc();
    rst = 1'b1;
    wdf_full = 1'b0;
    cyc();
    begin_list(32'h0000_E000);
    send_words(5, 100, 0, 1, 32'h50, 0);
    do_flush(1, 0);
    chk("t6_restart_addr", cap_a[0], 31'h0000_1C00);

    // Address wrap past 2^32.
    begin_list(32'hFFFF_FFC0);
    send_words(24, 80, 10, 0, 32'h0, 0);
    do_flush(0, 10);
    chk("wrap_addr2", cap_a[2], 31'h0000_0000);

    // Randomized lists with stalls, stray starts and flush-with-word.
    for (int r = 0; r < 30; r++) begin
      begin_list($urandom);
      send_words($urandom_range(0, 20), $urandom_range(40, 100),
                 $urandom_range(0, 40), 0, 32'h0, 1);
      do_flush($urandom_range(0, 1), $urandom_range(0, 40));
    end

    repeat (3) cyc();
    chk("final_queue_empty", beats.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
